// File: rtl/trojan_trigger.sv
// Watches valid plaintext blocks for the four-block sequence SEQ0..SEQ3 and latches a sticky trigger.
// Comparisons take one cycle; the design never stalls its input, and idle gaps longer than GAP_MAX restart detection.
module trojan_trigger #(
  parameter logic [127:0] SEQ0    = 128'h3243F6A8885A308D313198A2E0370734,
  parameter logic [127:0] SEQ1    = 128'h00112233445566778899AABBCCDDEEFF,
  parameter logic [127:0] SEQ2    = 128'h00000000000000000000000000000000,
  parameter logic [127:0] SEQ3    = 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF,
  parameter int unsigned  GAP_MAX = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         data_valid,
  input  logic [127:0] data,
  output logic         Tj_Trig,
  output logic [2:0]   trig_state,
  output logic [7:0]   gap_cnt
);

  typedef enum logic [2:0] {
    S0    = 3'd0,
    S1    = 3'd1,
    S2    = 3'd2,
    S3    = 3'd3,
    ARMED = 3'd4
  } state_t;

  localparam logic [7:0] GAP_LIM = 8'(GAP_MAX);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] gap_nxt;
  logic       hit0;
  logic       hit1;
  logic       hit2;
  logic       hit3;

  assign hit0 = (data == SEQ0);
  assign hit1 = (data == SEQ1);
  assign hit2 = (data == SEQ2);
  assign hit3 = (data == SEQ3);

  always_comb begin
    state_nxt = S0;
    gap_nxt   = 8'd0;
    case (state)
      S0: begin
        if (data_valid && hit0) begin
          state_nxt = S1;
        end
      end
      S1, S2, S3: begin
        if (data_valid) begin
          // The expected block wins over a restart so equal parameters still advance.
          if      (state == S1 && hit1) state_nxt = S2;
          else if (state == S2 && hit2) state_nxt = S3;
          else if (state == S3 && hit3) state_nxt = ARMED;
          else if (hit0)                state_nxt = S1;
          else                          state_nxt = S0;
        end else if (gap_cnt == GAP_LIM) begin
          state_nxt = S0;
        end else begin
          state_nxt = state;
          gap_nxt   = gap_cnt + 8'd1;
        end
      end
      ARMED: begin
        state_nxt = ARMED;
      end
      default: begin
        state_nxt = S0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S0;
      gap_cnt <= 8'd0;
      Tj_Trig <= 1'b0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_nxt;
      Tj_Trig <= (state_nxt == ARMED);
    end
  end

  assign trig_state = state;

endmodule

// File: tb/tb_trojan_trigger.sv
// Directed bench for trojan_trigger: vector table plus hand-written gap, sticky and async-reset sequences.
module tb_trojan_trigger;

  localparam logic [127:0] P0 = 128'h3243F6A8885A308D313198A2E0370734;
  localparam logic [127:0] P1 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] P2 = 128'h00000000000000000000000000000000;
  localparam logic [127:0] P3 = 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF;
  localparam logic [127:0] PX = 128'h00000000000000000000000000000001;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         data_valid = 1'b0;
  logic [127:0] data = '0;
  logic         Tj_Trig;
  logic [2:0]   trig_state;
  logic [7:0]   gap_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic         v;
    logic [127:0] d;
    logic [2:0]   st;
    logic [7:0]   gap;
    logic         trig;
  } vec_t;

  vec_t tbl[21];

  trojan_trigger dut (
    .clk        (clk),
    .rst        (rst),
    .data_valid (data_valid),
    .data       (data),
    .Tj_Trig    (Tj_Trig),
    .trig_state (trig_state),
    .gap_cnt    (gap_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic v, logic [127:0] d, logic [2:0] st, logic [7:0] gap, logic trig);
    vec_t r;
    r.v = v; r.d = d; r.st = st; r.gap = gap; r.trig = trig;
    return r;
  endfunction

  task automatic chk(input string name, input logic [2:0] st, input logic [7:0] gap, input logic trig);
    checks++;
    if (trig_state !== st || gap_cnt !== gap || Tj_Trig !== trig) begin
      failures++;
      $display("FAIL %s: got state=%0d gap=%0d trig=%0b, want state=%0d gap=%0d trig=%0b",
               name, trig_state, gap_cnt, Tj_Trig, st, gap, trig);
    end
  endtask

  // Drive on the falling edge, sample 1ns after the following rising edge.
  task automatic step(input logic v, input logic [127:0] d);
    @(negedge clk);
    data_valid = v;
    data       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    data_valid = 1'b0;
    #1;
    chk("reset_async", 3'd0, 8'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    tbl[0]  = mk(1'b1, P0, 3'd1, 8'd0, 1'b0);
    tbl[1]  = mk(1'b1, P1, 3'd2, 8'd0, 1'b0);
    tbl[2]  = mk(1'b1, P0, 3'd1, 8'd0, 1'b0);
    tbl[3]  = mk(1'b1, P1, 3'd2, 8'd0, 1'b0);
    tbl[4]  = mk(1'b0, P2, 3'd2, 8'd1, 1'b0);
    tbl[5]  = mk(1'b0, P2, 3'd2, 8'd2, 1'b0);
    tbl[6]  = mk(1'b1, P2, 3'd3, 8'd0, 1'b0);
    tbl[7]  = mk(1'b1, PX, 3'd0, 8'd0, 1'b0);
    tbl[8]  = mk(1'b0, P0, 3'd0, 8'd0, 1'b0);
    tbl[9]  = mk(1'b1, P0, 3'd1, 8'd0, 1'b0);
    tbl[10] = mk(1'b1, P1, 3'd2, 8'd0, 1'b0);
    tbl[11] = mk(1'b1, P2, 3'd3, 8'd0, 1'b0);
    tbl[12] = mk(1'b0, P3, 3'd3, 8'd1, 1'b0);
    tbl[13] = mk(1'b1, P0, 3'd1, 8'd0, 1'b0);
    tbl[14] = mk(1'b1, P1, 3'd2, 8'd0, 1'b0);
    tbl[15] = mk(1'b1, P2, 3'd3, 8'd0, 1'b0);
    tbl[16] = mk(1'b1, P3, 3'd4, 8'd0, 1'b1);
    tbl[17] = mk(1'b1, P0, 3'd4, 8'd0, 1'b1);
    tbl[18] = mk(1'b0, PX, 3'd4, 8'd0, 1'b1);
    tbl[19] = mk(1'b1, PX, 3'd4, 8'd0, 1'b1);
    tbl[20] = mk(1'b0, P0, 3'd4, 8'd0, 1'b1);

    #2;
    chk("reset_state", 3'd0, 8'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].v, tbl[i].d);
      chk($sformatf("vec%0d", i), tbl[i].st, tbl[i].gap, tbl[i].trig);
    end

    // Sticky trigger over random traffic.
    for (int i = 0; i < 1000; i++) begin
      step(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom});
      chk("armed_sticky", 3'd4, 8'd0, 1'b1);
    end

    // Maximum gap is tolerated.
    do_reset();
    step(1'b1, P0);
    chk("gap_start", 3'd1, 8'd0, 1'b0);
    for (int i = 1; i <= 255; i++) begin
      step(1'b0, P1);
      chk("gap_count", 3'd1, 8'(i), 1'b0);
    end
    step(1'b1, P1);
    chk("gap_255_advance", 3'd2, 8'd0, 1'b0);

    // One idle cycle more times out.
    do_reset();
    step(1'b1, P0);
    for (int i = 1; i <= 255; i++) step(1'b0, P1);
    chk("gap_at_max", 3'd1, 8'd255, 1'b0);
    step(1'b0, P1);
    chk("gap_timeout", 3'd0, 8'd0, 1'b0);
    step(1'b1, P1);
    chk("after_timeout_seq1", 3'd0, 8'd0, 1'b0);

    // Async reset out of ARMED between edges, then re-arm.
    do_reset();
    step(1'b1, P0);
    step(1'b1, P1);
    step(1'b1, P2);
    step(1'b1, P3);
    chk("armed_again", 3'd4, 8'd0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_between_edges", 3'd0, 8'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, P0);
    chk("rearm_1", 3'd1, 8'd0, 1'b0);
    step(1'b1, P1);
    chk("rearm_2", 3'd2, 8'd0, 1'b0);
    step(1'b1, P2);
    chk("rearm_3", 3'd3, 8'd0, 1'b0);
    step(1'b1, P3);
    chk("rearm_4", 3'd4, 8'd0, 1'b1);

    // Reset mid-sequence discards progress.
    do_reset();
    step(1'b1, P0);
    step(1'b1, P1);
    do_reset();
    step(1'b1, P2);
    chk("mid_reset_no_resume", 3'd0, 8'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trojan_trigger.md
TROJAN_TRIGGER -- requirements
Module: trojan_trigger

Interface
REQ-001 SHALL have parameter SEQ0, default 128'h3243F6A8885A308D313198A2E0370734, first plaintext of the trigger sequence.
REQ-002 SHALL have parameter SEQ1, default 128'h00112233445566778899AABBCCDDEEFF, second plaintext.
REQ-003 SHALL have parameter SEQ2, default 128'h00000000000000000000000000000000, third plaintext.
REQ-004 SHALL have parameter SEQ3, default 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF, fourth plaintext.
REQ-005 SHALL have parameter GAP_MAX, default 255, max idle cycles between sequence blocks (1..255).
REQ-006 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port data_valid  input  1  data carries a new plaintext block this cycle.
REQ-009 SHALL have port data  input  128  plaintext block entering the cipher.
REQ-010 SHALL have port Tj_Trig  output  1  registered trigger, feeds the leakage-stage trigger input.
REQ-011 SHALL have port trig_state  output  3  current FSM state encoding, debug.
REQ-012 SHALL have port gap_cnt  output  8  current idle-cycle count, debug.

Function
REQ-013 FSM states/encoding SHALL be: S0=0 (no match), S1=1 (SEQ0 seen), S2=2 (SEQ0,SEQ1 seen), S3=3 (SEQ0..SEQ2 seen), ARMED=4.
REQ-014 Comparisons SHALL be full 128-bit equality, sampled only in cycles with data_valid=1.
REQ-015 In S0..S3 with data_valid=1 and data equal to the next expected SEQn, state SHALL advance one step at that clock edge.
REQ-016 In S0..S3 with data_valid=1 and data not the expected value, state SHALL go to S1 if data==SEQ0, else S0 (restart, no other overlap tracking).
REQ-017 In S1..S3 each cycle with data_valid=0 SHALL increment gap_cnt; any data_valid=1 cycle SHALL clear gap_cnt to 0.
REQ-018 In S1..S3, when data_valid=0 and gap_cnt==GAP_MAX, state SHALL return to S0 and gap_cnt SHALL clear (timeout takes effect that edge).
REQ-019 In S0 and ARMED gap_cnt SHALL be held at 0.
REQ-020 S3 with data_valid=1 and data==SEQ3 SHALL enter ARMED; Tj_Trig SHALL be 1 from the edge entering ARMED (one cycle after the 4th matching block is presented).
REQ-021 ARMED SHALL be sticky: ignore data_valid/data, Tj_Trig held 1 until rst.
REQ-022 Tj_Trig SHALL be a registered decode of state==ARMED, no combinational path from data.
REQ-023 Parameters with equal values (e.g. SEQ0==SEQ1) SHALL follow REQ-015 priority: expected-value match checked before REQ-016 restart.
REQ-024 Unreachable encodings 5..7 SHALL recover to S0 on next edge.

Reset
REQ-025 rst=1 SHALL immediately, without clock, force state S0, Tj_Trig=0, trig_state=0, gap_cnt=0.
REQ-026 rst asserted mid-sequence or in ARMED SHALL discard all progress; after release detection restarts from S0.
REQ-027 First edge after rst deassertion SHALL evaluate inputs normally.

Verification
REQ-028 Back-to-back valid SEQ0,SEQ1,SEQ2,SEQ3 -> trig_state 1,2,3,4 after each edge; Tj_Trig=1 the cycle after SEQ3, stays 1 for 1000 cycles of random data.
REQ-029 SEQ0,SEQ1,SEQ0,SEQ1,SEQ2,SEQ3 -> state 1,2,1,2,3,4; Tj_Trig rises only after final SEQ3.
REQ-030 SEQ0 then 255 idle cycles then SEQ1 -> gap_cnt reaches 255, state stays S1, then S2; repeat with 256 idle -> state S0 at idle cycle 256, SEQ1 leaves S0.
REQ-031 SEQ0,SEQ1,SEQ2, then data=128'h1 -> state 0, Tj_Trig=0; data valid with data_valid=0 never advances state.
REQ-032 Enter ARMED, assert rst between edges -> Tj_Trig=0, trig_state=0 before next clk edge; full sequence afterward re-arms.
